processor_z: RTL and testbench



---
 rtl/processor_z.sv | 225 ++++++++++++++++++++++
 tb/tb_processor_z.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_z.sv
// processor_z: four-stage fetch/decode/execute/write-back core with a 512x32 instruction RAM
// and eight 32-bit registers. Define PROCZ_FORWARD_EN to add execute/write-back to decode bypass.
module processor_z (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [8:0]  addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic        working,
    output logic [31:0] valE,
    output logic [31:0] r0,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic [31:0] r3,
    output logic [31:0] r4,
    output logic [31:0] r5,
    output logic [31:0] r6,
    output logic [31:0] r7
);

    typedef enum logic [2:0] {
        OP_NOP,
        OP_IRMOV,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_XOR
    } op_e;

    logic [31:0] mem [0:511];
    logic [8:0]  ram_addr_s;

    logic [8:0]  pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    op_e         d_op_q, d_op_d;
    logic        d_we_q, d_we_d;
    logic [2:0]  d_dst_q, d_dst_d;
    logic [31:0] d_vala_q, d_vala_d;
    logic [31:0] d_valb_q, d_valb_d;
    logic [15:0] d_valc_q, d_valc_d;

    logic [31:0] vale_q, vale_d;
    logic        e_we_q, e_we_d;
    logic [2:0]  e_dst_q, e_dst_d;

    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];

    logic [3:0]  ra_s, rb_s;
    op_e         dec_op_s;
    logic        dec_we_s;
    logic [2:0]  dec_dst_s;
    logic [31:0] opa_s, opb_s;
    logic [31:0] alu_s;

    assign ram_addr_s = working ? pc_q : addr;
    assign ra_s       = ir_q[23:20];
    assign rb_s       = ir_q[19:16];

    // Host write port; RAM contents are deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr && !working) begin
            mem[ram_addr_s] <= wdata;
        end
    end

    // Decode the fetched word into an operation and destination.
    always_comb begin
        dec_op_s  = OP_NOP;
        dec_we_s  = 1'b0;
        dec_dst_s = 3'd0;
        case (ir_q[31:28])
            4'h1: begin
                if (ir_q[27:24] == 4'h0) begin
                    dec_op_s  = OP_IRMOV;
                    dec_we_s  = (rb_s != 4'hF);
                    dec_dst_s = rb_s[2:0];
                end else begin
                    dec_op_s  = OP_NOP;
                end
            end
            4'h2: begin
                dec_we_s  = (ra_s != 4'hF);
                dec_dst_s = ra_s[2:0];
                case (ir_q[27:24])
                    4'h0:    dec_op_s = OP_ADD;
                    4'h1:    dec_op_s = OP_SUB;
                    4'h2:    dec_op_s = OP_AND;
                    4'h3:    dec_op_s = OP_XOR;
                    default: begin
                        dec_op_s = OP_NOP;
                        dec_we_s = 1'b0;
                    end
                endcase
            end
            default: dec_op_s = OP_NOP;
        endcase
    end

    // Operand select: the instruction now executing is newer than the one writing back.
    always_comb begin
        if (ra_s == 4'hF) begin
            opa_s = 32'd0;
        end
`ifdef PROCZ_FORWARD_EN
        else if (d_we_q && (d_dst_q == ra_s[2:0])) begin
            opa_s = alu_s;
        end else if (e_we_q && (e_dst_q == ra_s[2:0])) begin
            opa_s = vale_q;
        end
`endif
        else begin
            opa_s = regs_q[ra_s[2:0]];
        end

        if (rb_s == 4'hF) begin
            opb_s = 32'd0;
        end
`ifdef PROCZ_FORWARD_EN
        else if (d_we_q && (d_dst_q == rb_s[2:0])) begin
            opb_s = alu_s;
        end else if (e_we_q && (e_dst_q == rb_s[2:0])) begin
            opb_s = vale_q;
        end
`endif
        else begin
            opb_s = regs_q[rb_s[2:0]];
        end
    end

    // Execute-stage ALU.
    always_comb begin
        case (d_op_q)
            OP_IRMOV: alu_s = {16'd0, d_valc_q};
            OP_ADD:   alu_s = d_vala_q + d_valb_q;
            OP_SUB:   alu_s = d_vala_q - d_valb_q;
            OP_AND:   alu_s = d_vala_q & d_valb_q;
            OP_XOR:   alu_s = d_vala_q ^ d_valb_q;
            default:  alu_s = 32'd0;
        endcase
    end

    // Pipeline advance; with working low every stage, including write-back, holds.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        d_op_d   = d_op_q;
        d_we_d   = d_we_q;
        d_dst_d  = d_dst_q;
        d_vala_d = d_vala_q;
        d_valb_d = d_valb_q;
        d_valc_d = d_valc_q;
        vale_d   = vale_q;
        e_we_d   = e_we_q;
        e_dst_d  = e_dst_q;
        regs_d   = regs_q;
        if (working) begin
            pc_d     = pc_q + 9'd1;
            ir_d     = mem[ram_addr_s];
            d_op_d   = dec_op_s;
            d_we_d   = dec_we_s;
            d_dst_d  = dec_dst_s;
            d_vala_d = opa_s;
            d_valb_d = opb_s;
            d_valc_d = ir_q[15:0];
            vale_d   = alu_s;
            e_we_d   = d_we_q;
            e_dst_d  = d_dst_q;
            if (e_we_q) begin
                regs_d[e_dst_q] = vale_q;
            end else begin
                regs_d[e_dst_q] = regs_q[e_dst_q];
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers; reset empties the pipeline so no write is pending at release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= 9'd0;
            ir_q     <= 32'd0;
            d_op_q   <= OP_NOP;
            d_we_q   <= 1'b0;
            d_dst_q  <= 3'd0;
            d_vala_q <= 32'd0;
            d_valb_q <= 32'd0;
            d_valc_q <= 16'd0;
            vale_q   <= 32'd0;
            e_we_q   <= 1'b0;
            e_dst_q  <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            d_op_q   <= d_op_d;
            d_we_q   <= d_we_d;
            d_dst_q  <= d_dst_d;
            d_vala_q <= d_vala_d;
            d_valb_q <= d_valb_d;
            d_valc_q <= d_valc_d;
            vale_q   <= vale_d;
            e_we_q   <= e_we_d;
            e_dst_q  <= e_dst_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign valE = vale_q;
    assign r0   = regs_q[0];
    assign r1   = regs_q[1];
    assign r2   = regs_q[2];
    assign r3   = regs_q[3];
    assign r4   = regs_q[4];
    assign r5   = regs_q[5];
    assign r6   = regs_q[6];
    assign r7   = regs_q[7];

endmodule

// File: tb/tb_processor_z.sv
// Directed testbench for processor_z: host load, program results, freeze, mid-run reset,
// forwarding behaviour and PC wrap.
module tb_processor_z;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [8:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [31:0] valE;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [31:0] rf [8];
    logic [31:0] prog [12];
    logic [31:0] prog_exp [8];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    processor_z dut (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (addr),
        .wr      (wr),
        .wdata   (wdata),
        .working (working),
        .valE    (valE),
        .r0      (r0),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7)
    );

    assign rf[0] = r0;
    assign rf[1] = r1;
    assign rf[2] = r2;
    assign rf[3] = r3;
    assign rf[4] = r4;
    assign rf[5] = r5;
    assign rf[6] = r6;
    assign rf[7] = r7;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        working = 1'b0;
        wr      = 1'b0;
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic host_write(input logic [8:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 512; i++) host_write(i[8:0], 32'd0);
    endtask

    task automatic load_program();
        for (int i = 0; i < 12; i++) host_write(i[8:0], prog[i]);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (valE !== 32'd0) begin
            errors++;
            $display("FAIL reset_valE: got %h expected %h", valE, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_r%0d: got %h expected %h", i, rf[i], 32'd0);
            end
        end
    endtask

    task automatic test_host_load();
        apply_reset();
        clear_ram();
        host_write(9'd0, 32'h10F00080);
        working = 1'b1;
        tick();
        tick();
        checks++;
        if (valE !== 32'd0) begin
            errors++;
            $display("FAIL load_valE_early: got %h expected %h", valE, 32'd0);
        end
        tick();
        checks++;
        if (valE !== 32'h80) begin
            errors++;
            $display("FAIL load_valE: got %h expected %h", valE, 32'h80);
        end
        checks++;
        if (r0 !== 32'd0) begin
            errors++;
            $display("FAIL load_r0_early: got %h expected %h", r0, 32'd0);
        end
        tick();
        checks++;
        if (r0 !== 32'h80) begin
            errors++;
            $display("FAIL load_r0: got %h expected %h", r0, 32'h80);
        end
        working = 1'b0;
    endtask

    // Runs the program with a host write held active; it must be ignored while working.
    task automatic test_program();
        apply_reset();
        load_program();
        addr    = 9'd11;
        wdata   = 32'd0;
        wr      = 1'b1;
        working = 1'b1;
        ticks(20);
        wr      = 1'b0;
        working = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== prog_exp[i]) begin
                errors++;
                $display("FAIL program_r%0d: got %h expected %h", i, rf[i], prog_exp[i]);
            end
        end
        checks++;
        if (valE !== 32'd0) begin
            errors++;
            $display("FAIL program_nop_valE: got %h expected %h", valE, 32'd0);
        end
    endtask

    task automatic test_freeze();
        apply_reset();
        working = 1'b1;
        ticks(6);
        working = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (valE !== 32'h83) begin
                errors++;
                $display("FAIL freeze_valE c%0d: got %h expected %h", c, valE, 32'h83);
            end
            checks++;
            if (r2 !== 32'h82) begin
                errors++;
                $display("FAIL freeze_r2 c%0d: got %h expected %h", c, r2, 32'h82);
            end
            checks++;
            if (r3 !== 32'd0) begin
                errors++;
                $display("FAIL freeze_r3 c%0d: got %h expected %h", c, r3, 32'd0);
            end
        end
        working = 1'b1;
        ticks(20);
        working = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== prog_exp[i]) begin
                errors++;
                $display("FAIL freeze_final_r%0d: got %h expected %h", i, rf[i], prog_exp[i]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        working = 1'b1;
        ticks(7);
        #2;
        reset_n = 1'b0;
        working = 1'b0;
        #1;
        checks++;
        if (valE !== 32'd0) begin
            errors++;
            $display("FAIL midreset_valE: got %h expected %h", valE, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== 32'd0) begin
                errors++;
                $display("FAIL midreset_r%0d: got %h expected %h", i, rf[i], 32'd0);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        ticks(5);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== 32'd0) begin
                errors++;
                $display("FAIL postreset_r%0d: got %h expected %h", i, rf[i], 32'd0);
            end
        end
        working = 1'b1;
        ticks(20);
        working = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== prog_exp[i]) begin
                errors++;
                $display("FAIL rerun_r%0d: got %h expected %h", i, rf[i], prog_exp[i]);
            end
        end
    endtask

    // r0 <- r0 + r0 after r0 <- 5. Without bypass a too-close consumer reads the reset value 0.
    task automatic test_forward();
        logic [31:0] exp_close;
`ifdef PROCZ_FORWARD_EN
        exp_close = 32'h0A;
`else
        exp_close = 32'h00;
`endif
        apply_reset();
        host_write(9'd0, 32'h10F00005);
        host_write(9'd1, 32'h20000000);
        for (int i = 2; i < 12; i++) host_write(i[8:0], 32'd0);
        working = 1'b1;
        ticks(10);
        working = 1'b0;
        checks++;
        if (r0 !== exp_close) begin
            errors++;
            $display("FAIL fwd_back_to_back: got %h expected %h", r0, exp_close);
        end

        apply_reset();
        host_write(9'd1, 32'd0);
        host_write(9'd2, 32'h20000000);
        working = 1'b1;
        ticks(10);
        working = 1'b0;
        checks++;
        if (r0 !== exp_close) begin
            errors++;
            $display("FAIL fwd_gap1: got %h expected %h", r0, exp_close);
        end

        apply_reset();
        host_write(9'd2, 32'd0);
        host_write(9'd4, 32'h20000000);
        working = 1'b1;
        ticks(12);
        working = 1'b0;
        checks++;
        if (r0 !== 32'h0A) begin
            errors++;
            $display("FAIL fwd_gap3: got %h expected %h", r0, 32'h0A);
        end
    endtask

    // mem[0] is patched mid-run, so r1 only changes if the fetch after 511 reads address 0.
    task automatic test_wrap();
        apply_reset();
        clear_ram();
        host_write(9'd511, 32'h10F201FF);
        working = 1'b1;
        ticks(300);
        working = 1'b0;
        host_write(9'd0, 32'h10F10055);
        checks++;
        if (r1 !== 32'd0) begin
            errors++;
            $display("FAIL wrap_r1_before: got %h expected %h", r1, 32'd0);
        end
        working = 1'b1;
        ticks(230);
        working = 1'b0;
        checks++;
        if (r2 !== 32'h1FF) begin
            errors++;
            $display("FAIL wrap_r2_addr511: got %h expected %h", r2, 32'h1FF);
        end
        checks++;
        if (r1 !== 32'h55) begin
            errors++;
            $display("FAIL wrap_r1_addr0: got %h expected %h", r1, 32'h55);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        working = 1'b0;
        wr      = 1'b0;
        addr    = 9'd0;
        wdata   = 32'd0;
        for (int i = 0; i < 8; i++) prog[i] = 32'h10F00080 + i * 32'h00010001;
        prog[8]  = 32'h20010000;
        prog[9]  = 32'h21230000;
        prog[10] = 32'h22450000;
        prog[11] = 32'h23670000;
        prog_exp[0] = 32'h00000101;
        prog_exp[1] = 32'h00000081;
        prog_exp[2] = 32'hFFFFFFFF;
        prog_exp[3] = 32'h00000083;
        prog_exp[4] = 32'h00000084;
        prog_exp[5] = 32'h00000085;
        prog_exp[6] = 32'h00000001;
        prog_exp[7] = 32'h00000087;

        test_reset();
        test_host_load();
        test_program();
        test_freeze();
        test_reset_midrun();
        test_forward();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
